// File: rtl/puf_soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_pkg
// Description : Shared definitions for the RO-PUF controller: FSM state
//               encoding, challenge-byte field positions, default parameter
//               values and challenge-byte helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_soc_pkg;

    // Default parameter values for the controller.
    localparam int C_PUF_LENGTH_DEF    = 16;
    localparam int C_RESP_BITS_DEF     = 8;
    localparam int C_CNT_WIDTH_DEF     = 16;
    localparam int C_SETTLE_CYCLES_DEF = 16;
    localparam int C_WINDOW_CYCLES_DEF = 1024;

    // Challenge byte k = {idx_a[7:4], idx_b[3:0]}.
    localparam int C_IDX_W     = 4;
    localparam int C_IDX_A_LSB = 4;
    localparam int C_IDX_B_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_CMP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [C_IDX_W-1:0] chal_idx_a(input logic [7:0] b);
        return b[C_IDX_A_LSB +: C_IDX_W];
    endfunction

    function automatic logic [C_IDX_W-1:0] chal_idx_b(input logic [7:0] b);
        return b[C_IDX_B_LSB +: C_IDX_W];
    endfunction

    // A challenge byte is usable only if it names two distinct, existing ROs.
    function automatic logic byte_legal(input logic [7:0] b, input int unsigned len);
        return (chal_idx_a(b) != chal_idx_b(b)) &&
               (32'(chal_idx_a(b)) < len) &&
               (32'(chal_idx_b(b)) < len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_soc_ro_counter.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_ro_counter
// Description : Two-flop synchroniser, rising-edge detector and saturating
//               edge counter for one asynchronous ring-oscillator signal.
// Ports       : i_clk, i_rst (async, active-high)
//               i_ro      - asynchronous RO output
//               i_clr     - synchronous clear of the count (wins over enable)
//               i_cnt_en  - count synchronised rising edges while high
//               o_cnt     - current count, saturates at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_ro_counter
    import puf_soc_pkg::*;
#(
    parameter int CNT_WIDTH = C_CNT_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ro,
    input  logic                 i_clr,
    input  logic                 i_cnt_en,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [1:0]           sync_q;
    logic                 prev_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 w_rise;

    assign w_rise = sync_q[1] & ~prev_q;
    assign o_cnt  = cnt_q;

    // The synchroniser keeps running outside the count window so that edges
    // already in flight when the window closes are still seen during drain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], i_ro};
            prev_q <= sync_q[1];
            if (i_clr) begin
                cnt_q <= '0;
            end else if (i_cnt_en && w_rise && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_soc_ro_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puf_soc_ro_ctrl
// Description : Ring-oscillator PUF controller. For each challenge byte it
//               enables two ROs, lets them settle, counts their edges over a
//               fixed window and writes one response bit (cnt_a > cnt_b).
//               Illegal challenge bytes (same RO twice or index out of range)
//               produce a 0 bit and set the sticky o_err flag.
// Ports       : i_clk, i_rst (async, active-high), i_start (start pulse)
//               i_chal   [8*RESP_BITS] - byte k = {idx_a, idx_b} for bit k
//               i_puf_ro [PUF_LENGTH]  - asynchronous RO outputs
//               o_puf_en [PUF_LENGTH]  - RO enables (at most two high)
//               o_busy, o_done (1-cycle pulse), o_resp [RESP_BITS], o_err
//               o_dbg_cnt_a/b [CNT_WIDTH] - only with PUF_SOC_RO_CTRL_DBG_EN
// Options     : define PUF_SOC_RO_CTRL_DBG_EN to expose the counts captured
//               in the compare state.
// Notes       : indices are 4 bits wide, so PUF_LENGTH is at most 16.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_soc_ro_ctrl
    import puf_soc_pkg::*;
#(
    parameter int PUF_LENGTH    = C_PUF_LENGTH_DEF,
    parameter int RESP_BITS     = C_RESP_BITS_DEF,
    parameter int CNT_WIDTH     = C_CNT_WIDTH_DEF,
    parameter int SETTLE_CYCLES = C_SETTLE_CYCLES_DEF,
    parameter int WINDOW_CYCLES = C_WINDOW_CYCLES_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [8*RESP_BITS-1:0] i_chal,
    input  logic [PUF_LENGTH-1:0]  i_puf_ro,
    output logic [PUF_LENGTH-1:0]  o_puf_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [RESP_BITS-1:0]   o_resp,
    output logic                   o_err
`ifdef PUF_SOC_RO_CTRL_DBG_EN
    ,
    output logic [CNT_WIDTH-1:0]   o_dbg_cnt_a,
    output logic [CNT_WIDTH-1:0]   o_dbg_cnt_b
`endif
);

    localparam int KW      = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t                 state_q;
    logic [8*RESP_BITS-1:0] chal_q;
    logic [KW-1:0]          k_q;
    logic [TMR_W-1:0]       tmr_q;
    logic [C_IDX_W-1:0]     idx_a_q;
    logic [C_IDX_W-1:0]     idx_b_q;
    logic                   legal_q;
    logic [PUF_LENGTH-1:0]  puf_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic [RESP_BITS-1:0]   resp_q;
    logic                   err_q;

    logic                   w_last;
    logic [KW-1:0]          w_k_nxt;
    logic [7:0]             w_nxt_byte;
    logic                   w_nxt_legal;
    logic [PUF_LENGTH-1:0]  w_nxt_mask;
    logic                   w_ro_a;
    logic                   w_ro_b;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;
    logic [CNT_WIDTH-1:0]   w_cnt_a;
    logic [CNT_WIDTH-1:0]   w_cnt_b;

    // Decode of the byte for the bit about to start: byte 0 straight from the
    // input when a run is accepted, otherwise the next latched byte.
    always_comb begin
        w_last  = (k_q == KW'(RESP_BITS - 1));
        w_k_nxt = w_last ? '0 : k_q + KW'(1);
        if (state_q == ST_IDLE) begin
            w_nxt_byte = i_chal[7:0];
        end else begin
            w_nxt_byte = chal_q[8*w_k_nxt +: 8];
        end
        w_nxt_legal = byte_legal(w_nxt_byte, PUF_LENGTH);
        w_nxt_mask  = '0;
        w_ro_a      = 1'b0;
        w_ro_b      = 1'b0;
        for (int i = 0; i < PUF_LENGTH; i++) begin
            if (chal_idx_a(w_nxt_byte) == C_IDX_W'(i)) w_nxt_mask[i] = 1'b1;
            if (chal_idx_b(w_nxt_byte) == C_IDX_W'(i)) w_nxt_mask[i] = 1'b1;
            if (idx_a_q == C_IDX_W'(i)) w_ro_a = i_puf_ro[i];
            if (idx_b_q == C_IDX_W'(i)) w_ro_b = i_puf_ro[i];
        end
    end

    assign w_cnt_clr = (state_q == ST_SETTLE);
    assign w_cnt_en  = (state_q == ST_COUNT) || (state_q == ST_DRAIN);

    puf_soc_ro_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_a (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ro     (w_ro_a),
        .i_clr    (w_cnt_clr),
        .i_cnt_en (w_cnt_en),
        .o_cnt    (w_cnt_a)
    );

    puf_soc_ro_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_b (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ro     (w_ro_b),
        .i_clr    (w_cnt_clr),
        .i_cnt_en (w_cnt_en),
        .o_cnt    (w_cnt_b)
    );

`ifdef PUF_SOC_RO_CTRL_DBG_EN
    logic [CNT_WIDTH-1:0] dbg_a_q;
    logic [CNT_WIDTH-1:0] dbg_b_q;
    assign o_dbg_cnt_a = dbg_a_q;
    assign o_dbg_cnt_b = dbg_b_q;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            chal_q   <= '0;
            k_q      <= '0;
            tmr_q    <= '0;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            legal_q  <= 1'b0;
            puf_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resp_q   <= '0;
            err_q    <= 1'b0;
`ifdef PUF_SOC_RO_CTRL_DBG_EN
            dbg_a_q  <= '0;
            dbg_b_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        chal_q  <= i_chal;
                        resp_q  <= '0;
                        err_q   <= 1'b0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        tmr_q   <= '0;
                        idx_a_q <= chal_idx_a(w_nxt_byte);
                        idx_b_q <= chal_idx_b(w_nxt_byte);
                        legal_q <= w_nxt_legal;
                        // Illegal bits skip straight to compare.
                        if (w_nxt_legal) begin
                            state_q  <= ST_SETTLE;
                            puf_en_q <= w_nxt_mask;
                        end else begin
                            state_q  <= ST_CMP;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                        tmr_q   <= '0;
                        state_q <= ST_COUNT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (tmr_q == TMR_W'(WINDOW_CYCLES - 1)) begin
                        tmr_q    <= '0;
                        puf_en_q <= '0;
                        state_q  <= ST_DRAIN;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Two cycles let edges still in the synchronisers land.
                    if (tmr_q == TMR_W'(1)) begin
                        tmr_q   <= '0;
                        state_q <= ST_CMP;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_CMP: begin
                    resp_q[k_q] <= legal_q && (w_cnt_a > w_cnt_b);
                    if (!legal_q) begin
                        err_q <= 1'b1;
                    end
`ifdef PUF_SOC_RO_CTRL_DBG_EN
                    dbg_a_q <= w_cnt_a;
                    dbg_b_q <= w_cnt_b;
`endif
                    if (w_last) begin
                        state_q <= ST_DONE;
                    end else begin
                        k_q     <= w_k_nxt;
                        tmr_q   <= '0;
                        idx_a_q <= chal_idx_a(w_nxt_byte);
                        idx_b_q <= chal_idx_b(w_nxt_byte);
                        legal_q <= w_nxt_legal;
                        if (w_nxt_legal) begin
                            state_q  <= ST_SETTLE;
                            puf_en_q <= w_nxt_mask;
                        end else begin
                            state_q  <= ST_CMP;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    puf_en_q <= '0;
                end
            endcase
        end
    end

    assign o_puf_en = puf_en_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_resp   = resp_q;
    assign o_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_soc_ro_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_soc_ro_ctrl
// Description : Self-checking bench for puf_soc_ro_ctrl. Two instances:
//               A (16 ROs, 8 bits, 16-bit counters) and B (8 ROs, 2 bits,
//               4-bit counters, for saturation and out-of-range indices).
//               Free-running ROs with fixed periods are gated by the DUT
//               enables. Expected bits come from ideal edge counts
//               (window time / RO period) with a +/-TOL uncertainty band;
//               bits whose outcome the band cannot decide are not checked.
//               Time unit: 1 unit = 0.5 ns, clock period 4 units (2 ns).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_soc_ro_ctrl;

    localparam int CLK_P  = 4;
    localparam int TOL    = 2;
    localparam int BUDGET = 4000;
    localparam int A_PL = 16, A_RB = 8, A_CW = 16, A_S = 4, A_W = 200;
    localparam int B_PL = 8,  B_RB = 2, B_CW = 4,  B_S = 4, B_W = 96;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [63:0] chal_a = '0;
    logic [15:0] chal_b = '0;
    logic [15:0] en_a, ro_a;
    logic [7:0]  en_b, ro_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [7:0]  resp_a;
    logic [1:0]  resp_b;
    wire  [15:0] ro_raw;
`ifdef PUF_SOC_RO_CTRL_DBG_EN
    logic [A_CW-1:0] dbg_a_a, dbg_b_a;
    logic [B_CW-1:0] dbg_a_b, dbg_b_b;
`endif

    int n_chk = 0, n_pass = 0;
    int nd_a = 0, nd_b = 0, pop_max = 0;

    // RO i period in time units: RO0 = 10 ns, RO1 = 14 ns, then 6,9,12.. ns.
    function automatic int ro_period(input int i);
        if (i == 0) return 20;
        if (i == 1) return 28;
        return 12 + 6 * (i - 2);
    endfunction

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ro
            logic r = 1'b0;
            initial forever #(ro_period(gi) / 2) r = ~r;
            assign ro_raw[gi] = r;
        end
    endgenerate

    assign ro_a = ro_raw & en_a;
    assign ro_b = ro_raw[7:0] & en_b;

    initial forever #(CLK_P / 2) clk = ~clk;

    puf_soc_ro_ctrl #(
        .PUF_LENGTH(A_PL), .RESP_BITS(A_RB), .CNT_WIDTH(A_CW),
        .SETTLE_CYCLES(A_S), .WINDOW_CYCLES(A_W)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_chal(chal_a),
        .i_puf_ro(ro_a), .o_puf_en(en_a), .o_busy(busy_a), .o_done(done_a),
        .o_resp(resp_a), .o_err(err_a)
`ifdef PUF_SOC_RO_CTRL_DBG_EN
        , .o_dbg_cnt_a(dbg_a_a), .o_dbg_cnt_b(dbg_b_a)
`endif
    );

    puf_soc_ro_ctrl #(
        .PUF_LENGTH(B_PL), .RESP_BITS(B_RB), .CNT_WIDTH(B_CW),
        .SETTLE_CYCLES(B_S), .WINDOW_CYCLES(B_W)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_chal(chal_b),
        .i_puf_ro(ro_b), .o_puf_en(en_b), .o_busy(busy_b), .o_done(done_b),
        .o_resp(resp_b), .o_err(err_b)
`ifdef PUF_SOC_RO_CTRL_DBG_EN
        , .o_dbg_cnt_a(dbg_a_b), .o_dbg_cnt_b(dbg_b_b)
`endif
    );

    always @(negedge clk) begin
        if (done_a) nd_a++;
        if (done_b) nd_b++;
        if ($countones(en_a) > pop_max) pop_max = $countones(en_a);
        if ($countones(en_b) > pop_max) pop_max = $countones(en_b);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit byte_ok(input logic [7:0] b, input int plen);
        int ia, ib;
        ia = int'(b[7:4]);
        ib = int'(b[3:0]);
        return (ia != ib) && (ia < plen) && (ib < plen);
    endfunction

    function automatic int ideal_cnt(input int idx, input int win);
        return (win * CLK_P) / ro_period(idx);
    endfunction

    // Returns {decidable, bit}.
    function automatic logic [1:0] model_bit(input logic [7:0] b, input int plen,
                                             input int win, input int cw);
        int sat, ea, eb, lo_a, hi_a, lo_b, hi_b;
        if (!byte_ok(b, plen)) return 2'b10;
        sat  = (1 << cw) - 1;
        ea   = ideal_cnt(int'(b[7:4]), win);
        eb   = ideal_cnt(int'(b[3:0]), win);
        lo_a = (ea - TOL < 0) ? 0 : ea - TOL;
        lo_b = (eb - TOL < 0) ? 0 : eb - TOL;
        hi_a = ea + TOL;
        hi_b = eb + TOL;
        if (lo_a > sat) lo_a = sat;
        if (lo_b > sat) lo_b = sat;
        if (hi_a > sat) hi_a = sat;
        if (hi_b > sat) hi_b = sat;
        if (lo_a > hi_b) return 2'b11;
        if (hi_a <= lo_b) return 2'b10;
        return 2'b00;
    endfunction

    // One full evaluation with model-derived expectations. glitch_at > 0
    // pulses start (with a different challenge) at that cycle of the run.
    task automatic eval_and_check(input string tag, input bit use_b, input logic [63:0] chal,
                                  input int glitch_at, input logic [63:0] glitch_chal);
        int nb, plen, win, cw, s, lat, exp_lat, d0;
        logic [7:0] exp_resp, mask, got, bt;
        logic [1:0] mb;
        logic exp_err;
        nb   = use_b ? B_RB : A_RB;
        plen = use_b ? B_PL : A_PL;
        win  = use_b ? B_W  : A_W;
        cw   = use_b ? B_CW : A_CW;
        s    = use_b ? B_S  : A_S;
        exp_lat = 2; exp_resp = '0; mask = '0; exp_err = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bt = chal[8*k +: 8];
            mb = model_bit(bt, plen, win, cw);
            if (byte_ok(bt, plen)) exp_lat += s + win + 3;
            else begin exp_lat += 1; exp_err = 1'b1; end
            mask[k]     = mb[1];
            exp_resp[k] = mb[0];
        end
        d0 = use_b ? nd_b : nd_a;
        @(negedge clk);
        if (use_b) begin chal_b = chal[15:0]; start_b = 1'b1; end
        else begin chal_a = chal; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        lat = 1;
        check({tag, "_busy_run"}, use_b ? busy_b : busy_a, 1);
        while (!(use_b ? done_b : done_a) && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            start_a = 1'b0;
            if (lat == glitch_at) begin chal_a = glitch_chal; start_a = 1'b1; end
        end
        start_a = 1'b0;
        got = use_b ? {6'b0, resp_b} : resp_a;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_resp"}, got & mask, exp_resp & mask);
        check({tag, "_err"}, use_b ? err_b : err_a, exp_err);
        @(posedge clk); #1;
        check({tag, "_done_width"}, use_b ? done_b : done_a, 0);
        check({tag, "_busy_idle"}, use_b ? busy_b : busy_a, 0);
        repeat (3) @(posedge clk);
        #1;
        got = use_b ? {6'b0, resp_b} : resp_a;
        check({tag, "_resp_hold"}, got & mask, exp_resp & mask);
        check({tag, "_done_count"}, (use_b ? nd_b : nd_a) - d0, 1);
    endtask

    initial begin
        logic [63:0] c;
        int lat, d0;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_resp", resp_a, 0);
        check("rst_err", err_a, 0);
        @(negedge clk); rst = 1'b0;

        // Byte0 = 0x01 (RO0 10 ns vs RO1 14 ns) -> 1; rest random.
        c = {$urandom(), $urandom()}; c[7:0] = 8'h01;
        eval_and_check("b01", 1'b0, c, 0, '0);
        check("b01_bit0", resp_a[0], 1);
        c = {$urandom(), $urandom()}; c[7:0] = 8'h10;
        eval_and_check("b10", 1'b0, c, 0, '0);
        check("b10_bit0", resp_a[0], 0);
        c = {$urandom(), $urandom()}; c[7:0] = 8'h33;
        eval_and_check("b33", 1'b0, c, 0, '0);
        check("b33_bit0", resp_a[0], 0);
        check("b33_err", err_a, 1);

        // All bits compare RO0 against RO1.
        eval_and_check("all01", 1'b0, 64'h0101_0101_0101_0101, 0, '0);
        check("all01_resp", resp_a, 8'hFF);
`ifdef PUF_SOC_RO_CTRL_DBG_EN
        begin
            int da, db;
            da = int'(dbg_a_a) - ideal_cnt(0, A_W);
            db = int'(dbg_b_a) - ideal_cnt(1, A_W);
            check("dbg_cnt_a_close", (da <= TOL && da >= -TOL), 1);
            check("dbg_cnt_b_close", (db <= TOL && db >= -TOL), 1);
        end
`endif

        // Random challenges, one with an illegal byte at a random position.
        for (int r = 0; r < 4; r++) begin
            c = {$urandom(), $urandom()};
            if (r == 2) c[8*$urandom_range(0, 7) +: 8] = 8'h55;
            eval_and_check($sformatf("rand%0d", r), 1'b0, c, 0, '0);
        end

        // Start pulse during COUNT of bit 0 must be ignored.
        eval_and_check("restart", 1'b0, 64'h1001_1001_1001_1001, A_S + 10,
                       64'h0110_0110_0110_0110);
        check("restart_resp", resp_a, 8'h55);

        // Saturating 4-bit counters: 0x23 -> both at 15 -> 0; 0x27 -> 1.
        eval_and_check("sat", 1'b1, 64'h2723, 0, '0);
        check("sat_resp", resp_b, 2'b10);
        // Index 9 does not exist in an 8-RO bank.
        eval_and_check("oor", 1'b1, 64'h0391, 0, '0);
        check("oor_err", err_b, 1);
        eval_and_check("randb", 1'b1, 64'($urandom_range(0, 65535)), 0, '0);

        // Reset during SETTLE of bit 3 aborts the run.
        d0 = nd_a;
        @(negedge clk); chal_a = 64'h1001_1001_1001_1001; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; lat = 1;
        while (lat < 3 * (A_S + A_W + 3) + 2) begin @(posedge clk); #1; lat++; end
        check("abort_settle_en", en_a, 16'h0003);
        check("abort_settle_busy", busy_a, 1);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        check("abort_en_zero", en_a, 0);
        check("abort_busy_zero", busy_a, 0);
        check("abort_resp_zero", resp_a, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", nd_a - d0, 0);
        eval_and_check("post_rst", 1'b0, 64'h1001_1001_1001_1001, 0, '0);
        check("post_rst_resp", resp_a, 8'h55);

        check("en_popcount_le2", pop_max <= 2, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
